// File: rtl/ula_ctrl.sv
// ula_ctrl: arbitrates two requesters onto one shared, fixed-latency ULA.
// An accepted operation is captured, driven to the ULA for LAT cycles, and
// its result is returned as a one-cycle rsp_valid pulse tagged with the
// owning requester id.
// Build option: define ULA_CTRL_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise requester 0 has fixed priority.
module ula_ctrl #(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_op,
    output logic [7:0] ula_a,
    output logic [7:0] ula_b,
    output logic [2:0] ula_op,
    input  logic [8:0] ula_s,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [8:0] rsp_s,
    output logic       busy
);

    // WAIT lasts LAT cycles: the counter is loaded with LAT-1 and leaves at 0.
    localparam logic [3:0] LAT_M1 = 4'(LAT - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] op_q, op_d;
    logic       id_q, id_d;
    logic [8:0] rsp_s_q, rsp_s_d;
    logic       rsp_id_q, rsp_id_d;

    logic       grant_s;
    logic       idle_s;
    logic       accept_s;
    logic       wait_done_s;

`ifdef ULA_CTRL_RR_EN
    logic       last_q, last_d;
`endif

    // Pick the requester that would win if both are presenting.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ULA_CTRL_RR_EN
            grant_s = ~last_q;
`else
            grant_s = 1'b0;
`endif
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Handshake: ready only in IDLE, only for the winner, never during reset.
    always_comb begin
        idle_s      = (state_q == S_IDLE) && !rst;
        req0_ready  = idle_s && req0_valid && !grant_s;
        req1_ready  = idle_s && req1_valid && grant_s;
        accept_s    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        wait_done_s = (state_q == S_WAIT) && (cnt_q == 4'd0);
    end

    // State register; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic of the IDLE -> ISSUE -> WAIT -> RESP loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture on accept, count in WAIT, latch the result.
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        rsp_s_d  = rsp_s_q;
        rsp_id_d = rsp_id_q;
`ifdef ULA_CTRL_RR_EN
        last_d   = last_q;
`endif
        if (accept_s) begin
            id_d = grant_s;
            if (grant_s) begin
                a_d  = req1_a;
                b_d  = req1_b;
                op_d = req1_op;
            end else begin
                a_d  = req0_a;
                b_d  = req0_b;
                op_d = req0_op;
            end
`ifdef ULA_CTRL_RR_EN
            last_d = grant_s;
`endif
        end else begin
            id_d = id_q;
        end
        case (state_q)
            S_ISSUE: cnt_d = LAT_M1;
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = 4'd0;
                end
            end
            default: cnt_d = cnt_q;
        endcase
        if (wait_done_s) begin
            rsp_s_d  = ula_s;
            rsp_id_d = id_q;
        end else begin
            rsp_s_d  = rsp_s_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 4'd0;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            op_q     <= 3'd0;
            id_q     <= 1'b0;
            rsp_s_q  <= 9'd0;
            rsp_id_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            rsp_s_q  <= rsp_s_d;
            rsp_id_q <= rsp_id_d;
        end
    end

`ifdef ULA_CTRL_RR_EN
    // Last-grant register; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Outputs decoded from registered state; ULA operands hold between ops.
    always_comb begin
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_id    = rsp_id_q;
        rsp_s     = rsp_s_q;
        ula_a     = a_q;
        ula_b     = b_q;
        ula_op    = op_q;
    end

endmodule

// File: tb/tb_ula_ctrl.sv
// Bench for ula_ctrl: two instances (LAT=1 and LAT=3) driven side by side,
// each attached to a pipelined ULA model, checked every cycle against a
// transaction-level reference model (accept cycle -> busy window, response
// cycle, result). Honours ULA_CTRL_RR_EN for the arbitration expectations.
module tb_ula_ctrl;

    localparam int N = 2;
`ifdef ULA_CTRL_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [N];
    logic       r0v  [N];
    logic       r0r  [N];
    logic [7:0] r0a  [N];
    logic [7:0] r0b  [N];
    logic [2:0] r0op [N];
    logic       r1v  [N];
    logic       r1r  [N];
    logic [7:0] r1a  [N];
    logic [7:0] r1b  [N];
    logic [2:0] r1op [N];
    logic [7:0] ua   [N];
    logic [7:0] ub   [N];
    logic [2:0] uop  [N];
    logic [8:0] us   [N];
    logic       rv   [N];
    logic       rid  [N];
    logic [8:0] rs   [N];
    logic       bsy  [N];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [8:0] ula_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a, 1'b0};
            default: return {1'b0, b};
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [8:0] pipe [16];
        // ULA model: result appears LAT cycles after the operands.
        always @(posedge clk) begin
            pipe[0] <= ula_fn(ua[g], ub[g], uop[g]);
            for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
        end
        assign us[g] = pipe[(g == 0) ? 0 : 2];

        ula_ctrl #(.LAT((g == 0) ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req0_valid (r0v[g]),
            .req0_ready (r0r[g]),
            .req0_a     (r0a[g]),
            .req0_b     (r0b[g]),
            .req0_op    (r0op[g]),
            .req1_valid (r1v[g]),
            .req1_ready (r1r[g]),
            .req1_a     (r1a[g]),
            .req1_b     (r1b[g]),
            .req1_op    (r1op[g]),
            .ula_a      (ua[g]),
            .ula_b      (ub[g]),
            .ula_op     (uop[g]),
            .ula_s      (us[g]),
            .rsp_valid  (rv[g]),
            .rsp_id     (rid[g]),
            .rsp_s      (rs[g]),
            .busy       (bsy[g])
        );
    end

    int checks;
    int errors;
    int cyc;
    bit chk_en;
    bit keep;
    int viol;

    // reference model state
    int         m_free [N];
    int         m_rcyc [N];
    bit         m_last [N];
    logic [8:0] m_ps   [N];
    logic [8:0] m_ss   [N];
    logic       m_pid  [N];
    logic       m_sid  [N];
    logic [7:0] m_ua   [N];
    logic [7:0] m_ub   [N];
    logic [2:0] m_uop  [N];
    bit         e0     [N];
    bit         e1     [N];
    int         seen_cyc [N];
    logic [8:0] seen_s   [N];
    logic       seen_id  [N];
    int         glog [N][8];
    int         gcnt [N];

    task automatic chk(input string tag, input int i, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h cyc=%0d", tag, i, obs, exp, cyc);
        end
    endtask

    task automatic model_reset(input int i);
        m_free[i] = 0;
        m_rcyc[i] = -1;
        m_last[i] = 1'b1;
        m_ss[i]   = 9'd0;
        m_sid[i]  = 1'b0;
        m_ua[i]   = 8'd0;
        m_ub[i]   = 8'd0;
        m_uop[i]  = 3'd0;
    endtask

    task automatic set_req(input int i, input int j, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] op);
        if (j == 0) begin
            r0a[i] = a; r0b[i] = b; r0op[i] = op; r0v[i] = 1'b1;
        end else begin
            r1a[i] = a; r1b[i] = b; r1op[i] = op; r1v[i] = 1'b1;
        end
    endtask

    task automatic rnd_req(input int i, input int j);
        set_req(i, j, 8'($urandom), 8'($urandom), 3'($urandom));
    endtask

    // One clock cycle: check at negedge, update model at posedge, then drive.
    task automatic tick();
        bit idle;
        bit g;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            idle = (cyc >= m_free[i]) && !rst[i];
            if (r0v[i] && r1v[i]) g = RR ? !m_last[i] : 1'b0;
            else                  g = r1v[i];
            e0[i] = idle && r0v[i] && !g;
            e1[i] = idle && r1v[i] && g;
            if (cyc == m_rcyc[i]) begin
                m_sid[i] = m_pid[i];
                m_ss[i]  = m_ps[i];
            end
            if (rv[i] === 1'b1 && seen_cyc[i] < 0) begin
                seen_cyc[i] = cyc;
                seen_s[i]   = rs[i];
                seen_id[i]  = rid[i];
            end
            if (r1r[i] === 1'b1 && bsy[i] === 1'b1) viol++;
            if (chk_en) begin
                chk("req0_ready", i, 32'(r0r[i]), 32'(e0[i]));
                chk("req1_ready", i, 32'(r1r[i]), 32'(e1[i]));
                chk("busy",       i, 32'(bsy[i]), 32'(cyc < m_free[i]));
                chk("rsp_valid",  i, 32'(rv[i]),  32'(cyc == m_rcyc[i]));
                chk("rsp_id",     i, 32'(rid[i]), 32'(m_sid[i]));
                chk("rsp_s",      i, 32'(rs[i]),  32'(m_ss[i]));
                chk("ula_a",      i, 32'(ua[i]),  32'(m_ua[i]));
                chk("ula_b",      i, 32'(ub[i]),  32'(m_ub[i]));
                chk("ula_op",     i, 32'(uop[i]), 32'(m_uop[i]));
            end
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst[i]) begin
                model_reset(i);
            end else if (e0[i] || e1[i]) begin
                m_free[i] = cyc + lat_of(i) + 3;
                m_rcyc[i] = cyc + lat_of(i) + 2;
                m_pid[i]  = e1[i];
                m_last[i] = e1[i];
                m_ua[i]   = e1[i] ? r1a[i]  : r0a[i];
                m_ub[i]   = e1[i] ? r1b[i]  : r0b[i];
                m_uop[i]  = e1[i] ? r1op[i] : r0op[i];
                m_ps[i]   = ula_fn(m_ua[i], m_ub[i], m_uop[i]);
                if (gcnt[i] < 8) begin
                    glog[i][gcnt[i]] = e1[i] ? 1 : 0;
                    gcnt[i]++;
                end
            end
        end
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rst[i] && e0[i]) begin
                if (keep) rnd_req(i, 0); else r0v[i] = 1'b0;
            end
            if (!rst[i] && e1[i]) begin
                if (keep) rnd_req(i, 1); else r1v[i] = 1'b0;
            end
        end
    endtask

    int t0;

    initial begin
        checks = 0; errors = 0; cyc = 0; chk_en = 1'b0; keep = 1'b0; viol = 0;
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1;
            r0v[i] = 1'b0; r0a[i] = 8'd0; r0b[i] = 8'd0; r0op[i] = 3'd0;
            r1v[i] = 1'b0; r1a[i] = 8'd0; r1b[i] = 8'd0; r1op[i] = 3'd0;
            model_reset(i);
            seen_cyc[i] = -1;
            gcnt[i] = 0;
        end

        // reset held two cycles, then everything idle and zero
        tick();
        chk_en = 1'b1;
        tick();
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        repeat (3) tick();

        // directed: add on LAT=1 (req0), carry on LAT=3 (req1)
        t0 = cyc;
        set_req(0, 0, 8'h01, 8'h01, 3'b000);
        set_req(1, 1, 8'hFF, 8'h01, 3'b000);
        repeat (10) tick();
        chk("lat1_rsp_cyc", 0, 32'(seen_cyc[0]), 32'(t0 + 3));
        chk("lat1_rsp_s",   0, 32'(seen_s[0]),   32'h002);
        chk("lat1_rsp_id",  0, 32'(seen_id[0]),  32'd0);
        chk("lat3_rsp_cyc", 1, 32'(seen_cyc[1]), 32'(t0 + 5));
        chk("lat3_rsp_s",   1, 32'(seen_s[1]),   32'h100);
        chk("lat3_rsp_id",  1, 32'(seen_id[1]),  32'd1);

        // contention: both requesters valid continuously
        for (int i = 0; i < N; i++) rst[i] = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b0;
            gcnt[i] = 0;
            for (int k = 0; k < 8; k++) glog[i][k] = -1;
            rnd_req(i, 0);
            rnd_req(i, 1);
        end
        keep = 1'b1;
        viol = 0;
        for (int k = 0; k < 40 && (gcnt[0] < 4 || gcnt[1] < 4); k++) tick();
        keep = 1'b0;
        for (int i = 0; i < N; i++) begin
            r0v[i] = 1'b0;
            r1v[i] = 1'b0;
        end
        repeat (8) tick();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++)
                chk("grant_order", i, 32'(glog[i][k]), RR ? 32'(k % 2) : 32'd0);
        chk("req1_ready_while_busy", 0, 32'(viol), 32'd0);

        // reset pulsed during WAIT abandons the operation
        for (int i = 0; i < N; i++) begin
            seen_cyc[i] = -1;
            rnd_req(i, 0);
        end
        tick();
        tick();
        for (int i = 0; i < N; i++) rst[i] = 1'b1;
        tick();
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        #3;
        for (int i = 0; i < N; i++) chk("busy_after_rst", i, 32'(bsy[i]), 32'd0);
        repeat (8) tick();
        for (int i = 0; i < N; i++) chk("no_rsp_after_rst", i, 32'(seen_cyc[i]), 32'hFFFF_FFFF);

        // the next request completes normally
        t0 = cyc;
        for (int i = 0; i < N; i++) begin
            seen_cyc[i] = -1;
            rnd_req(i, 1);
        end
        repeat (8) tick();
        for (int i = 0; i < N; i++) begin
            chk("post_rst_rsp_cyc", i, 32'(seen_cyc[i]), 32'(t0 + lat_of(i) + 2));
            chk("post_rst_rsp_id",  i, 32'(seen_id[i]),  32'd1);
        end

        // randomized traffic with withdrawals and occasional resets
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                rst[i] = ($urandom_range(0, 99) == 0);
                if (!r0v[i]) begin
                    if ($urandom_range(0, 1) == 1) rnd_req(i, 0);
                end else if ($urandom_range(0, 15) == 0) begin
                    r0v[i] = 1'b0;
                end
                if (!r1v[i]) begin
                    if ($urandom_range(0, 1) == 1) rnd_req(i, 1);
                end else if ($urandom_range(0, 15) == 0) begin
                    r1v[i] = 1'b0;
                end
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b0;
            r0v[i] = 1'b0;
            r1v[i] = 1'b0;
        end
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ula_ctrl.md
ULA_CTRL -- requirements
Module: ula_ctrl

Interface
REQ-001 Parameter LAT, default 1: ULA result latency in clk cycles from operands presented to ula_s valid; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 opcode.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths/meaning as REQ-004..007, for requester 1.
REQ-009 ula_a, ula_b  output  8 each  operands driven to the shared ULA.
REQ-010 ula_op  output  3  opcode driven to the shared ULA.
REQ-011 ula_s  input  9  ULA result, including carry in bit 8.
REQ-012 rsp_valid  output  1  one-cycle pulse: rsp_s/rsp_id valid.
REQ-013 rsp_id  output  1  requester that owns the response.
REQ-014 rsp_s  output  9  captured ULA result.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, with transitions IDLE->ISSUE on accept, ISSUE->WAIT, WAIT->RESP when the wait counter expires, and RESP->IDLE unconditionally.
REQ-017 reqN_ready SHALL be combinational: high only in IDLE and only for the granted requester; the transfer happens on valid&&ready.
REQ-018 On transfer, the block SHALL register the operands, opcode and requester id, then move to ISSUE.
REQ-019 ula_a, ula_b and ula_op SHALL be driven from the captured registers from ISSUE through the end of WAIT, and SHALL hold their last values in IDLE and RESP.
REQ-020 WAIT SHALL last exactly LAT cycles (4-bit down-counter); ula_s SHALL be sampled into rsp_s at the end of the last WAIT cycle.
REQ-021 For an accept in cycle T, rsp_valid SHALL be high in cycle T+LAT+2 only, with rsp_id = the accepted requester.
REQ-022 rsp_s and rsp_id SHALL hold until the next capture; there is no response backpressure.
REQ-023 Peak throughput SHALL be one operation per LAT+3 cycles, and no request SHALL be accepted while busy.
REQ-024 The opcode SHALL be forwarded unmodified, with no legality check.
REQ-025 If only one requester is valid in IDLE, that requester SHALL be granted regardless of arbitration mode.
REQ-026 A valid request deasserted before ready SHALL have no effect.

Reset
REQ-027 rst SHALL force IDLE, with ready=0 (both), rsp_valid=0, rsp_id=0, rsp_s=0, ula_a/ula_b/ula_op=0, counter=0, busy=0, and last-grant=1 (so requester 0 wins first under RR).
REQ-028 rst asserted mid-operation SHALL abandon the operation with no rsp_valid; rst has priority over every transition.

Configuration
REQ-029 The macro ULA_CTRL_RR_EN SHALL select the arbitration mode.
REQ-030 With ULA_CTRL_RR_EN defined, simultaneous requests SHALL be granted to the requester not granted last, and the last-grant register SHALL update on each accept.
REQ-031 Without ULA_CTRL_RR_EN, requester 0 SHALL always win simultaneous requests, and no last-grant register SHALL exist.

Verification
REQ-032 Reset scenario: assert rst 2 cycles, then release -> all outputs 0, busy=0.
REQ-033 Single request, LAT=1, ULA model op 3'b000=add: req0 a=8'h01 b=8'h01 op=000 accepted cycle T -> rsp_valid at T+3, rsp_id=0, rsp_s=9'h002.
REQ-034 Carry, LAT=3: req1 a=8'hFF b=8'h01 op=000 accepted cycle T -> rsp_valid at T+5, rsp_id=1, rsp_s=9'h100.
REQ-035 Contention: both valid continuously for 4 operations -> RR_EN: grant order 0,1,0,1; no RR_EN: 0,0,0,0; req1_ready never high while busy.
REQ-036 Reset mid-op: rst pulsed during WAIT -> no rsp_valid, busy=0 next cycle, and the next request completes normally.
